// File: rtl/divider_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
// The master side issues operations and consumes results; the slave side is the divider.
interface divider_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, is_signed, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, is_signed, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_seq.sv
// Iterative radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// One quotient bit per cycle on magnitudes; signs are restored when the last bit is produced.
module divider_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    divider_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] div_abs_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dbz_reg;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             is_zero, is_ovf, last_iter;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] rem_next, quo_next;

    always_comb begin
        a_neg     = bus.is_signed & bus.dividend[WIDTH-1];
        b_neg     = bus.is_signed & bus.divisor[WIDTH-1];
        a_abs     = a_neg ? -bus.dividend : bus.dividend;
        b_abs     = b_neg ? -bus.divisor  : bus.divisor;
        is_zero   = (bus.divisor == '0);
        is_ovf    = bus.is_signed & (bus.dividend == MIN_NEG) & (bus.divisor == '1);
        last_iter = (count_reg == LAST_COUNT);
        // Partial remainder stays below the divisor, so WIDTH+1 bits hold both the
        // shifted value and the sign of the trial subtraction.
        shifted   = {rem_reg, quo_reg[WIDTH-1]};
        trial     = shifted - {1'b0, div_abs_reg};
        rem_next  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_next  = {quo_reg[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_next = (is_zero | is_ovf) ? DONE : BUSY;
            end
            BUSY: begin
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg     <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            div_abs_reg   <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        q_neg_reg   <= a_neg ^ b_neg;
                        r_neg_reg   <= a_neg;
                        div_abs_reg <= b_abs;
                        quo_reg     <= a_abs;
                        rem_reg     <= '0;
                        count_reg   <= '0;
                        if (is_zero) begin
                            quotient_reg  <= '1;
                            remainder_reg <= bus.dividend;
                            dbz_reg       <= 1'b1;
                        end else if (is_ovf) begin
                            quotient_reg  <= bus.dividend;
                            remainder_reg <= '0;
                            dbz_reg       <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    rem_reg   <= rem_next;
                    quo_reg   <= quo_next;
                    count_reg <= count_reg + 1'b1;
                    if (last_iter) begin
                        quotient_reg  <= q_neg_reg ? -quo_next : quo_next;
                        remainder_reg <= r_neg_reg ? -rem_next : rem_next;
                        dbz_reg       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq at WIDTH=8: directed corner cases, backpressure,
// mid-operation reset and randomized operations against an arithmetic reference.
module tb_divider_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    divider_seq_if #(.WIDTH(W)) bus ();

    divider_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: language division truncates toward zero and % follows the dividend.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z, output int lat);
        int sa, sb;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = int'(a);
            sb = int'(b);
        end
        if (b == 0) begin
            q = '1; r = a; z = 1'b1; lat = 1;
        end else if (s && sa == -128 && sb == -1) begin
            q = a; r = '0; z = 1'b0; lat = 1;
        end else begin
            q = W'(sa / sb); r = W'(sa % sb); z = 1'b0; lat = W + 1;
        end
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                            input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.is_signed = s;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.dividend  = W'($urandom);
        bus.divisor   = W'($urandom);
        bus.is_signed = 1'($urandom);
    endtask

    // Latency counts the acceptance edge as 1.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input string tag);
        logic [W-1:0] eq, er;
        logic         ez;
        int           elat, lat;
        model(a, b, s, eq, er, ez, elat);
        start_op(a, b, s, tag);
        wait_result(lat);
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_quotient"}, 32'(bus.quotient), 32'(eq));
        check({tag, "_remainder"}, 32'(bus.remainder), 32'(er));
        check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(ez));
        $display("op %s: a=%02h b=%02h signed=%0d -> q=%02h r=%02h dbz=%0d lat=%0d",
                 tag, a, b, s, bus.quotient, bus.remainder, bus.div_by_zero, lat);
        finish_op(tag);
    endtask

    initial begin
        int            lat;
        logic          seen;
        logic [W-1:0]  ra, rb;
        logic          rs;

        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_quotient", 32'(bus.quotient), 32'd0);
        check("reset_remainder", 32'(bus.remainder), 32'd0);
        check("reset_dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'd100, 8'd7, 1'b0, "u100_7");
        run_op(8'hF9, 8'h02, 1'b1, "s_m7_2");
        run_op(8'h07, 8'hFE, 1'b1, "s_7_m2");
        run_op(8'h05, 8'h00, 1'b1, "s_div0");
        run_op(8'h05, 8'h00, 1'b0, "u_div0");
        run_op(8'h80, 8'hFF, 1'b1, "s_ovf");
        run_op(8'h80, 8'hFF, 1'b0, "u_80_ff");
        run_op(8'h00, 8'h09, 1'b1, "zero_dividend");

        // Backpressure: result held while a new request waits at the input.
        start_op(8'd50, 8'd5, 1'b0, "bp");
        wait_result(lat);
        check("bp_latency", 32'(lat), 32'(W + 1));
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.dividend  = 8'd33;
        bus.divisor   = 8'd3;
        bus.is_signed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_hold_quotient", 32'(bus.quotient), 32'd10);
            check("bp_hold_remainder", 32'(bus.remainder), 32'd0);
        end
        $display("op bp: 50/5 held 5 cycles q=%02h r=%02h", bus.quotient, bus.remainder);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp_handshake_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_handshake_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_next_accepted", 32'(bus.in_ready), 32'd0);
        wait_result(lat);
        check("bp_next_latency", 32'(lat), 32'(W + 1));
        check("bp_next_quotient", 32'(bus.quotient), 32'd11);
        check("bp_next_remainder", 32'(bus.remainder), 32'd0);
        $display("op bp_next: 33/3 -> q=%02h r=%02h lat=%0d", bus.quotient, bus.remainder, lat);
        finish_op("bp_next");

        // Reset in the middle of an iteration sequence discards the operation.
        start_op(8'd200, 8'd3, 1'b0, "rst_mid");
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_quotient", 32'(bus.quotient), 32'd0);
        check("rst_mid_remainder", 32'(bus.remainder), 32'd0);
        check("rst_mid_dbz", 32'(bus.div_by_zero), 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            seen = seen | bus.out_valid;
        end
        check("rst_mid_no_result", 32'(seen), 32'd0);
        $display("op rst_mid: 200/3 aborted at iteration 4");
        run_op(8'd9, 8'd3, 1'b0, "after_rst");

        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = 8'h00;
                1:       rb = 8'hFF;
                2:       rb = 8'h01;
                default: rb = W'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) ra = 8'h80;
            rs = 1'($urandom);
            run_op(ra, rb, rs, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
- Iterative radix-2 restoring divider; the inverse operation to the team's combinational multiplier array.
- Computes quotient and remainder of two WIDTH-bit operands, signed or unsigned, with RISC-V DIV/DIVU/REM/REMU semantics.
- Sits beside the multiplier in the vector execution lane.
- Uses valid/ready handshakes on both input and output sides.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  divider can accept a new operation.
- dividend  input  WIDTH  numerator A.
- divisor  input  WIDTH  denominator B.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  output  1  quotient/remainder valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  A/B, truncated toward zero.
- remainder  output  WIDTH  A - B*quotient; sign follows dividend.
- div_by_zero  output  1  flag: divisor was 0 (qualified by out_valid).

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; quotient, remainder, div_by_zero = 0; iteration counter = 0. Reset mid-operation aborts without producing a result.
- States are IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register the absolute values of the operands when is_signed, plus the sign of the quotient (sA^sB) and the sign of the remainder (sA).
  - Divisor==0 → DONE next cycle: quotient = all ones, remainder = dividend, div_by_zero=1.
  - Signed overflow (is_signed, A = 1<<(WIDTH-1), B = all ones) → DONE next cycle: quotient = A, remainder = 0, div_by_zero=0.
  - Otherwise → BUSY, with counter=0, partial remainder=0 and shift register=|A|.
- BUSY:
  - One quotient bit per cycle.
  - Each cycle, shift {R, Q} left by 1 and compute trial = R - |B| at WIDTH+1 bits.
  - If trial ≥ 0, R = trial and Q[0] = 1; otherwise R is unchanged and Q[0] = 0.
  - After exactly WIDTH iterations (counter == WIDTH-1), go to DONE.
  - Sign fixup is applied on that transition: negate Q if the quotient sign is set, negate R if the remainder sign is set.
- DONE:
  - out_valid=1; quotient, remainder and div_by_zero are held stable.
  - in_ready=0.
  - On out_valid&out_ready → IDLE and out_valid drops next cycle.
- Latency, normal case: accept at edge T, out_valid high from edge T+WIDTH+1. Special cases: out_valid from edge T+1.
- No overlap: in_ready=0 in BUSY and DONE. A new operation can be accepted in the cycle after the result handshake at the earliest.
- in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- Result registers keep their last values in IDLE. They are meaningful only while out_valid=1.
- Unsigned mode never triggers overflow. Operands with the MSB set are treated as large positives.
- A zero dividend with a nonzero divisor follows the normal path and yields quotient=0, remainder=0.

Test Plan:
- WIDTH=8, unsigned 100/7 → quotient=14, remainder=2, div_by_zero=0; out_valid exactly 9 cycles after acceptance.
- WIDTH=8, signed 0xF9(-7)/0x02 → quotient=0xFD(-3), remainder=0xFF(-1). Also signed 7/0xFE(-2) → quotient=0xFD, remainder=0x01.
- WIDTH=8, 5/0 (both modes) → quotient=0xFF, remainder=0x05, div_by_zero=1; out_valid 1 cycle after acceptance.
- WIDTH=8, signed 0x80/0xFF → quotient=0x80, remainder=0x00, 1-cycle latency. The same operands unsigned → quotient=0x00, remainder=0x80 after the full 9 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands presented.
  - Required: outputs stable, in_ready=0, new operands not taken.
  - Raise out_ready: one handshake, then the next operation is accepted the following cycle.
- Assert rst at iteration 4 of 200/3 → next cycle state=IDLE, out_valid=0, in_ready=1, outputs=0. A subsequent 9/3 then yields quotient=3, remainder=0.
